branch_predictor: RTL

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits directly upstream of the jump control stage.
  - Predicts taken/not-taken and the target for the fetch PC; fetch redirects on a taken prediction.
  - The prediction travels down the pipeline as flag bit 16 (predicted-taken).
- When a conditional branch resolves, jump control returns the outcome here and the entry is trained.
- JALR is never predicted.

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_if.sv | 28 ++
 rtl/branch_predictor_sat_ctr2.sv | 23 ++
 rtl/branch_predictor.sv | 137 +++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: the 2-bit
// saturating counter encodings plus the reset and allocate counter values.
package erv24_bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Counter value after reset: weakly not-taken, so a single taken outcome
  // is enough to flip the prediction.
  localparam ctr_e CTR_RESET = CTR_WNT;

  // Counter value for a newly allocated entry: weakly taken.
  localparam ctr_e CTR_ALLOC = CTR_WT;

  // The upper counter bit is the taken/not-taken decision.
  function automatic logic ctr_is_taken(input ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The master side is the pipeline (fetch PC, resolved branches); the slave
// side is the predictor (prediction and statistics).
interface branch_predictor_if;

  logic        ena;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output ena, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken,
    input  pred_taken, pred_target, stat_branches, stat_mispredicts
  );

  modport slave (
    input  ena, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken,
    output pred_taken, pred_target, stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating counter update: one step toward taken or not-taken,
// holding at ST and SNT.
module bp_sat_ctr2
  import erv24_bp_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  // Next counter value from current value and resolved outcome.
  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_o = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from fetch_pc; training happens at the clock edge
// when a conditional branch resolves. There is no lookup/update bypass: a
// lookup in the same cycle as an update sees the pre-update entry.
// Optional feature: define BP_STATS_EN to build the resolved-branch and
// misprediction counters; otherwise both statistic outputs read 0.
module branch_predictor
  import erv24_bp_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // Table storage kept in flops so that reset can clear every entry.
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [30:0]      tgt_q   [ENTRIES];
  ctr_e             ctr_q   [ENTRIES];

  logic [IDX_BITS-1:0] f_idx_s;
  logic [TAG_W-1:0]    f_tag_s;
  logic                f_hit_s;

  logic [IDX_BITS-1:0] u_idx_s;
  logic [TAG_W-1:0]    u_tag_s;
  logic                u_hit_s;
  ctr_e                u_ctr_next_s;

  logic                upd_we_d;
  logic                upd_valid_d;
  logic [TAG_W-1:0]    upd_tag_d;
  logic [30:0]         upd_tgt_d;
  ctr_e                upd_ctr_d;

  // Lookup side.
  assign f_idx_s = bp.fetch_pc[IDX_BITS+1:2];
  assign f_tag_s = bp.fetch_pc[31:IDX_BITS+2];
  assign f_hit_s = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);

  assign bp.pred_taken  = bp.ena & f_hit_s & ctr_is_taken(ctr_q[f_idx_s]);
  assign bp.pred_target = f_hit_s ? {tgt_q[f_idx_s], 1'b0} : 32'h0000_0000;

  // Update side.
  assign u_idx_s = bp.upd_pc[IDX_BITS+1:2];
  assign u_tag_s = bp.upd_pc[31:IDX_BITS+2];
  assign u_hit_s = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i   (ctr_q[u_idx_s]),
    .taken_i (bp.upd_taken),
    .ctr_o   (u_ctr_next_s)
  );

  // Decide whether and how the indexed entry is rewritten by a resolved branch.
  always_comb begin
    upd_we_d    = 1'b0;
    upd_valid_d = valid_q[u_idx_s];
    upd_tag_d   = tag_q[u_idx_s];
    upd_tgt_d   = tgt_q[u_idx_s];
    upd_ctr_d   = ctr_q[u_idx_s];
    if (bp.ena && bp.upd_valid) begin
      if (u_hit_s) begin
        upd_we_d  = 1'b1;
        upd_ctr_d = u_ctr_next_s;
        if (bp.upd_taken) begin
          upd_tgt_d = bp.upd_target[31:1];
        end else begin
          upd_tgt_d = tgt_q[u_idx_s];
        end
      end else if (bp.upd_taken) begin
        // Taken miss replaces whatever lived at this index.
        upd_we_d    = 1'b1;
        upd_valid_d = 1'b1;
        upd_tag_d   = u_tag_s;
        upd_tgt_d   = bp.upd_target[31:1];
        upd_ctr_d   = CTR_ALLOC;
      end else begin
        upd_we_d = 1'b0;
      end
    end else begin
      upd_we_d = 1'b0;
    end
  end

  // Table register: async clear, single-entry write per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 31'h0000_0000;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (upd_we_d) begin
      valid_q[u_idx_s] <= upd_valid_d;
      tag_q[u_idx_s]   <= upd_tag_d;
      tgt_q[u_idx_s]   <= upd_tgt_d;
      ctr_q[u_idx_s]   <= upd_ctr_d;
    end
  end

  logic unused_s;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Resolved-branch and misprediction counters, wrapping at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= 32'h0000_0000;
      stat_mispredicts_q <= 32'h0000_0000;
    end else if (bp.ena && bp.upd_valid) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (bp.upd_taken != bp.upd_pred_taken) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
  assign unused_s = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_target[0]};
`else
  assign bp.stat_branches    = 32'h0000_0000;
  assign bp.stat_mispredicts = 32'h0000_0000;
  assign unused_s = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_target[0],
                      bp.upd_pred_taken};
`endif

endmodule
